// File: rtl/neuron_sequencer_if.sv
// Bus between the neuron sequencer, its weight memory and the combinational neuron datapath.
// The master side is the sequencer; the slave side is the memory/datapath pair.
interface neuron_sequencer_if #(
    parameter int ADDR_W = 7
);
    // Weight memory read channel
    logic              w_req_o;
    logic [ADDR_W-1:0] w_addr_o;
    logic [7:0]        w_data_i;
    logic              w_valid_i;

    // Neuron datapath operands and results
    logic [7:0]        weight_o;
    logic [7:0]        v_mem_in_o;
    logic [7:0]        beta_o;
    logic [7:0]        v_th_o;
    logic              function_sel_o;
    logic              spike_i;
    logic [7:0]        v_mem_out_i;

    modport master (
        output w_req_o, w_addr_o, weight_o, v_mem_in_o, beta_o, v_th_o, function_sel_o,
        input  w_data_i, w_valid_i, spike_i, v_mem_out_i
    );

    modport slave (
        input  w_req_o, w_addr_o, weight_o, v_mem_in_o, beta_o, v_th_o, function_sel_o,
        output w_data_i, w_valid_i, spike_i, v_mem_out_i
    );
endinterface

// File: rtl/neuron_sequencer.sv
// Sequences one SNN timestep: per neuron, integrate the weights of all active inputs,
// then one leak/fire pass; membrane potentials live in a local register file.
module neuron_sequencer #(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W      = $clog2(NUM_INPUTS * NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic [NUM_INPUTS-1:0]  spikes_in_i,
    input  logic [7:0]             beta_i,
    input  logic [7:0]             v_th_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NUM_NEURONS-1:0] spikes_out_o,
    neuron_sequencer_if.master     bus
);

    localparam int NI_W = $clog2(NUM_INPUTS);
    localparam int NN_W = $clog2(NUM_NEURONS);
    localparam logic [NI_W-1:0] LAST_IN  = NI_W'(NUM_INPUTS - 1);
    localparam logic [NN_W-1:0] LAST_NRN = NN_W'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FETCH,
        S_INTEG,
        S_FIRE,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [NN_W-1:0]        r_neuron_idx;
    logic [NI_W-1:0]        r_input_idx;
    logic [NUM_INPUTS-1:0]  r_spikes;
    logic [7:0]             r_beta;
    logic [7:0]             r_v_th;
    logic [7:0]             r_weight;
    logic                   r_w_req;
    logic [ADDR_W-1:0]      r_w_addr;
    logic                   r_func_sel;
    logic                   r_busy;
    logic                   r_done;
    logic [NUM_NEURONS-1:0] r_spike_acc;
    logic [NUM_NEURONS-1:0] r_spikes_out;
    logic [7:0]             r_vmem [NUM_NEURONS];

    logic [ADDR_W-1:0]      w_addr;
    logic                   w_last_in;
    logic                   w_last_nrn;

    assign w_addr     = ADDR_W'(r_neuron_idx) * ADDR_W'(NUM_INPUTS) + ADDR_W'(r_input_idx);
    assign w_last_in  = (r_input_idx == LAST_IN);
    assign w_last_nrn = (r_neuron_idx == LAST_NRN);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_neuron_idx <= '0;
            r_input_idx  <= '0;
            r_spikes     <= '0;
            r_beta       <= '0;
            r_v_th       <= '0;
            r_weight     <= '0;
            r_w_req      <= 1'b0;
            r_w_addr     <= '0;
            r_func_sel   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_spike_acc  <= '0;
            r_spikes_out <= '0;
            // NOTE: the membrane file is a small flop array (not a RAM macro), so it
            // can and must be reset here; an abort must leave no stale potentials.
            for (int n = 0; n < NUM_NEURONS; n++) begin
                r_vmem[n] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_spikes     <= spikes_in_i;
                        r_beta       <= beta_i;
                        r_v_th       <= v_th_i;
                        r_neuron_idx <= '0;
                        r_input_idx  <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SCAN;
                    end else if (clear_i) begin
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            r_vmem[n] <= '0;
                        end
                    end
                end

                S_SCAN: begin
                    if (r_spikes[r_input_idx]) begin
                        r_w_req  <= 1'b1;
                        r_w_addr <= w_addr;
                        r_state  <= S_FETCH;
                    end else if (w_last_in) begin
                        r_func_sel <= 1'b1;
                        r_state    <= S_FIRE;
                    end else begin
                        r_input_idx <= r_input_idx + NI_W'(1);
                    end
                end

                // Request and address are held untouched until the memory completes.
                S_FETCH: begin
                    if (bus.w_valid_i) begin
                        r_w_req  <= 1'b0;
                        r_weight <= bus.w_data_i;
                        r_state  <= S_INTEG;
                    end
                end

                S_INTEG: begin
                    r_vmem[r_neuron_idx] <= bus.v_mem_out_i;
                    if (w_last_in) begin
                        r_func_sel <= 1'b1;
                        r_state    <= S_FIRE;
                    end else begin
                        r_input_idx <= r_input_idx + NI_W'(1);
                        r_state     <= S_SCAN;
                    end
                end

                S_FIRE: begin
                    r_vmem[r_neuron_idx]      <= bus.v_mem_out_i;
                    r_spike_acc[r_neuron_idx] <= bus.spike_i;
                    r_func_sel                <= 1'b0;
                    if (w_last_nrn) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_neuron_idx <= r_neuron_idx + NN_W'(1);
                        r_input_idx  <= '0;
                        r_state      <= S_SCAN;
                    end
                end

                // Publishing the accumulated vector only here keeps spikes_out_o
                // stable for the whole of the next timestep.
                S_DONE: begin
                    r_spikes_out <= r_spike_acc;
                    r_state      <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign spikes_out_o       = r_spikes_out;
    assign bus.w_req_o        = r_w_req;
    assign bus.w_addr_o       = r_w_addr;
    assign bus.weight_o       = r_weight;
    assign bus.v_mem_in_o     = r_vmem[r_neuron_idx];
    assign bus.beta_o         = r_beta;
    assign bus.v_th_o         = r_v_th;
    assign bus.function_sel_o = r_func_sel;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer: weight memory with programmable wait states,
// a behavioural neuron datapath, a vector table and hand-written corner sequences.
module tb_neuron_sequencer;

    localparam int NI = 16;
    localparam int NN = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [NI-1:0] spikes_in_i = '0;
    logic [7:0]    beta_i = '0;
    logic [7:0]    v_th_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [NN-1:0] spikes_out_o;

    neuron_sequencer_if #(.ADDR_W(AW)) bus ();

    neuron_sequencer #(
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .clear_i     (clear_i),
        .spikes_in_i (spikes_in_i),
        .beta_i      (beta_i),
        .v_th_i      (v_th_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .spikes_out_o(spikes_out_o),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Weight memory: mode 0 = constant 0x40, mode 1 = 16*(neuron+1), else addr+1.
    int mem_wait = 0;
    int wmode = 0;
    int wait_cnt = 0;

    function automatic logic [7:0] mem_word(input int mode, input logic [AW-1:0] a);
        if (mode == 0) return 8'h40;
        if (mode == 1) return 8'((int'(a) / NI + 1) * 16);
        return 8'(int'(a) + 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (bus.w_req_o && !bus.w_valid_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    assign bus.w_valid_i = bus.w_req_o && (wait_cnt >= mem_wait);
    assign bus.w_data_i  = mem_word(wmode, bus.w_addr_o);

    // Neuron: sel=0 saturating add; sel=1 leak v*beta>>8, fire and reset at >= v_th.
    function automatic logic [8:0] neuron_model(input logic sel, input logic [7:0] v,
                                                input logic [7:0] w, input logic [7:0] beta,
                                                input logic [7:0] vth);
        int sum;
        int leaked;
        sum    = int'(v) + int'(w);
        leaked = (int'(v) * int'(beta)) >> 8;
        if (!sel) return {1'b0, (sum > 255) ? 8'hFF : 8'(sum)};
        if (leaked >= int'(vth)) return {1'b1, 8'h00};
        return {1'b0, 8'(leaked)};
    endfunction

    assign {bus.spike_i, bus.v_mem_out_i} = neuron_model(bus.function_sel_o, bus.v_mem_in_o,
                                                         bus.weight_o, bus.beta_o, bus.v_th_o);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Observations of the most recent timestep
    int              busy_cnt, req_cnt, fsel_cnt, stab_err, wt_err;
    bit              seen_done;
    logic [AW-1:0]   addr_q[$];
    logic [7:0]      vin_start[NN];
    logic [NN-1:0]   spk_out;

    task automatic run_ts(input logic [NI-1:0] spk, input logic [7:0] beta,
                          input logic [7:0] vth, input int mode, input int wt, input bit poke);
        bit            prev_req, cap_pend, new_nrn;
        logic [7:0]    cap_exp;
        logic [AW-1:0] prev_addr;
        int            nrn;
        busy_cnt = 0; req_cnt = 0; fsel_cnt = 0; stab_err = 0; wt_err = 0;
        addr_q.delete();
        for (int n = 0; n < NN; n++) vin_start[n] = 8'hxx;
        wmode = mode; mem_wait = wt;
        @(negedge clk);
        spikes_in_i = spk; beta_i = beta; v_th_i = vth; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        new_nrn = 1'b1; nrn = 0; seen_done = 1'b0; prev_req = 1'b0; cap_pend = 1'b0;
        prev_addr = '0; cap_exp = '0;
        for (int cyc = 0; cyc < 5000 && !seen_done; cyc++) begin
            if (done_o) seen_done = 1'b1;
            if (busy_o) begin
                busy_cnt++;
                if (new_nrn && nrn < NN) begin
                    vin_start[nrn] = bus.v_mem_in_o;
                    new_nrn = 1'b0;
                end
            end
            if (bus.function_sel_o) begin
                fsel_cnt++; nrn++; new_nrn = 1'b1;
            end
            if (cap_pend && bus.weight_o !== cap_exp) wt_err++;
            cap_pend = 1'b0;
            if (bus.w_req_o) begin
                if (!prev_req) begin
                    addr_q.push_back(bus.w_addr_o);
                    req_cnt++;
                end else if (bus.w_addr_o !== prev_addr) begin
                    stab_err++;
                end
                if (bus.w_valid_i) begin
                    cap_pend = 1'b1;
                    cap_exp  = mem_word(mode, bus.w_addr_o);
                end
            end
            prev_req = bus.w_req_o; prev_addr = bus.w_addr_o;
            start_i = poke && (cyc == 20);
            clear_i = poke && (cyc == 20);
            if (!seen_done) @(negedge clk);
        end
        start_i = 1'b0; clear_i = 1'b0;
        check("done_seen", seen_done, 1);
        @(negedge clk);
        check("done_one_cycle", done_o, 0);
        spk_out = spikes_out_o;
    endtask

    task automatic check_addrs(input string name, input logic [NI-1:0] spk);
        int k = 0;
        int bad = 0;
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) begin
                if (spk[i]) begin
                    if (k >= addr_q.size() || addr_q[k] !== AW'(n * NI + i)) bad++;
                    k++;
                end
            end
        end
        check(name, bad, 0);
    endtask

    task automatic do_clear();
        @(negedge clk); clear_i = 1'b1;
        @(negedge clk); clear_i = 1'b0;
    endtask

    typedef struct {
        logic [NI-1:0] spk;
        logic [7:0]    beta;
        logic [7:0]    vth;
        int            mode;
        int            wt;
        int            exp_busy;
        int            exp_req;
        logic [NN-1:0] exp_out;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nz;
        bit  got_fire, got_req;
        logic [7:0] exp_vin[NN];

        vecs[0] = '{16'h0000, 8'h80, 8'h10, 0, 0, 136,   0, 8'h00};
        vecs[1] = '{16'h0008, 8'hFF, 8'h40, 1, 0, 152,   8, 8'hF0};
        vecs[2] = '{16'hFFFF, 8'h80, 8'h30, 0, 0, 392, 128, 8'hFF};
        vecs[3] = '{16'h8001, 8'h80, 8'h60, 1, 3, 216,  16, 8'hE0};
        vecs[4] = '{16'hFFFF, 8'h00, 8'h00, 0, 0, 392, 128, 8'hFF};

        // Reset state
        #12;
        check("rst_busy",     busy_o, 0);
        check("rst_done",     done_o, 0);
        check("rst_spk_out",  spikes_out_o, 0);
        check("rst_w_req",    bus.w_req_o, 0);
        check("rst_w_addr",   bus.w_addr_o, 0);
        check("rst_weight",   bus.weight_o, 0);
        check("rst_beta",     bus.beta_o, 0);
        check("rst_vth",      bus.v_th_o, 0);
        check("rst_fsel",     bus.function_sel_o, 0);
        check("rst_vmem_in",  bus.v_mem_in_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // Table-driven timesteps, each from a cleared register file
        for (int v = 0; v < 5; v++) begin
            do_clear();
            run_ts(vecs[v].spk, vecs[v].beta, vecs[v].vth, vecs[v].mode, vecs[v].wt, 1'b0);
            nz = 0;
            for (int n = 0; n < NN; n++) if (vin_start[n] !== 8'h00) nz++;
            check($sformatf("v%0d_busy_cycles", v), busy_cnt, vecs[v].exp_busy);
            check($sformatf("v%0d_req_count", v),   req_cnt,  vecs[v].exp_req);
            check($sformatf("v%0d_fire_passes", v), fsel_cnt, NN);
            check($sformatf("v%0d_addr_stable", v), stab_err, 0);
            check($sformatf("v%0d_weight_cap", v),  wt_err,   0);
            check($sformatf("v%0d_vin_cleared", v), nz,       0);
            check($sformatf("v%0d_spikes_out", v),  spk_out,  vecs[v].exp_out);
            check_addrs($sformatf("v%0d_addr_seq", v), vecs[v].spk);
        end

        // start/clear pulsed while busy are ignored; potentials persist
        do_clear();
        run_ts(16'h0008, 8'hFF, 8'hFF, 1, 0, 1'b1);
        check("poke_busy_cycles", busy_cnt, 152);
        check("poke_spikes_out",  spk_out, 8'h00);
        repeat (3) @(negedge clk);
        check("poke_not_queued",  busy_o, 0);
        exp_vin = '{8'd15, 8'd31, 8'd47, 8'd63, 8'd79, 8'd95, 8'd111, 8'd127};
        run_ts(16'h0000, 8'h80, 8'hFF, 0, 0, 1'b0);
        for (int n = 0; n < NN; n++) check($sformatf("persist_vin%0d", n), vin_start[n], exp_vin[n]);
        check("persist_busy_cycles", busy_cnt, 136);

        // clear in IDLE zeroes every membrane register
        do_clear();
        run_ts(16'h0000, 8'h00, 8'h00, 0, 0, 1'b0);
        for (int n = 0; n < NN; n++) check($sformatf("clear_vin%0d", n), vin_start[n], 0);
        check("clear_spikes_out", spk_out, 8'hFF);

        // Reset in the middle of a fetch on neuron 1
        wmode = 0; mem_wait = 3;
        @(negedge clk);
        spikes_in_i = '1; beta_i = 8'h80; v_th_i = 8'hFF; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        got_fire = 1'b0; got_req = 1'b0;
        for (int c = 0; c < 2000 && !got_fire; c++) begin
            @(negedge clk);
            if (bus.function_sel_o) got_fire = 1'b1;
        end
        for (int c = 0; c < 200 && !got_req; c++) begin
            @(negedge clk);
            if (bus.w_req_o) got_req = 1'b1;
        end
        check("abort_reached_fetch", got_fire && got_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_w_req",    bus.w_req_o, 0);
        check("abort_busy",     busy_o, 0);
        check("abort_fsel",     bus.function_sel_o, 0);
        check("abort_spk_out",  spikes_out_o, 0);
        check("abort_w_addr",   bus.w_addr_o, 0);
        check("abort_weight",   bus.weight_o, 0);
        check("abort_beta",     bus.beta_o, 0);
        check("abort_vmem_in",  bus.v_mem_in_o, 0);
        @(negedge clk); rst_n = 1'b1;
        run_ts(16'h0000, 8'hFF, 8'h00, 0, 0, 1'b0);
        nz = 0;
        for (int n = 0; n < NN; n++) if (vin_start[n] !== 8'h00) nz++;
        check("post_rst_vin_zero",    nz, 0);
        check("post_rst_busy_cycles", busy_cnt, 136);
        check("post_rst_spikes_out",  spk_out, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
